// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter (8 data bits, 1 stop bit)
// Optional even parity bit between data and stop when UART_TX_FIFO_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int DIV_RATE = 260
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_busy,
    output logic                     tx_end,
    output logic                     tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DIV_RATE > 2) ? $clog2(DIV_RATE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATE - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(DIV_RATE - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_FIFO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          tx_end_q;
`ifdef UART_TX_FIFO_PARITY_EN
    logic          parity_q;
`endif

    logic       push;
    logic       pop;
    logic       div_last;
    logic [7:0] head;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_end   = tx_end_q;
    assign tx       = tx_q;

    assign div_last = (div_q == DIV_LAST);
    assign head     = mem_q[rd_ptr_q];
    assign push     = wr_en && !full;
    // The last STOP cycle pops directly so queued frames run back to back.
    assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && div_last));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (wr_en && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            tx_end_q <= 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx_end_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= head;
`ifdef UART_TX_FIFO_PARITY_EN
                        parity_q <= ^head;
`endif
                        state_q <= S_START;
                        div_q   <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (div_last) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_DATA: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
`ifdef UART_TX_FIFO_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
`ifdef UART_TX_FIFO_PARITY_EN
                S_PARITY: begin
                    if (div_last) begin
                        div_q   <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (pop) begin
                            shift_q <= head;
`ifdef UART_TX_FIFO_PARITY_EN
                            parity_q <= ^head;
`endif
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                        // Raised one edge early so the pulse covers the final stop cycle.
                        if (div_q == DIV_PRE) tx_end_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench: serial receiver model checks every frame against queued bytes
module tb_uart_tx_fifo;
    localparam int DEPTH    = 4;
    localparam int DIV_RATE = 4;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam int FRAME = 11 * DIV_RATE;
`else
    localparam int FRAME = 10 * DIV_RATE;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       tx_busy;
    logic       tx_end;
    logic       tx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tx_end_cnt = 0;
    logic [7:0] exp_q[$];
    int start_cyc[$];

    logic       rx_active = 1'b0;
    int         rx_k = 0;
    logic [7:0] rx_byte = 8'h00;

    uart_tx_fifo #(.DEPTH(DEPTH), .DIV_RATE(DIV_RATE)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_busy(tx_busy), .tx_end(tx_end), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && tx_end) tx_end_cnt++;
    end

    // Receiver: samples each bit two cycles into its DIV_RATE window.
    always @(negedge clk) begin
        if (!reset) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && tx == 1'b0) begin
                rx_active = 1'b1;
                rx_k = 0;
                start_cyc.push_back(cyc);
            end else if (rx_active) begin
                rx_k++;
            end
            if (rx_active) begin
                if (rx_k == 2) check("start_bit", 32'(tx), 32'd0);
                if (rx_k >= 6 && rx_k <= 34 && (rx_k % 4) == 2)
                    rx_byte[(rx_k - 6) / 4] = tx;
`ifdef UART_TX_FIFO_PARITY_EN
                if (rx_k == 38) check("parity_bit", 32'(tx), 32'(^rx_byte));
`endif
                if (rx_k == FRAME - 2) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    check("tx_end_early", 32'(tx_end), 32'd0);
                end
                if (rx_k == FRAME - 1) begin
                    check("tx_end_last_stop", 32'(tx_end), 32'd1);
                    if (exp_q.size() == 0) check("rx_unexpected_byte", 32'(rx_byte), 32'hFFFF_FFFF);
                    else check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic put(input logic [7:0] b, input bit accept);
        wr_en = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((tx_busy || !empty || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int ends0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_end", 32'(tx_end), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte: latency and full frame
        ends0 = tx_end_cnt;
        put(8'h55, 1'b1);
        check("lat_tx_still_high", 32'(tx), 32'd1);
        check("lat_count1", 32'(count), 32'd1);
        check("lat_not_empty", 32'(empty), 32'd0);
        @(negedge clk);
        check("lat_tx_low", 32'(tx), 32'd0);
        check("lat_busy", 32'(tx_busy), 32'd1);
        check("lat_popped_empty", 32'(empty), 32'd1);
        wait_idle("idle_55");
        check("ends_55", 32'(tx_end_cnt - ends0), 32'd1);

        // Three consecutive writes: contiguous frames
        ends0 = tx_end_cnt;
        start_cyc.delete();
        put(8'h41, 1'b1);
        check("b2b_count_a", 32'(count), 32'd1);
        put(8'h42, 1'b1);
        check("b2b_count_b", 32'(count), 32'd1);
        put(8'h43, 1'b1);
        check("b2b_count_peak", 32'(count), 32'd2);
        wait_idle("idle_b2b");
        check("ends_b2b", 32'(tx_end_cnt - ends0), 32'd3);
        check("b2b_frames", 32'(start_cyc.size()), 32'd3);
        if (start_cyc.size() == 3) begin
            check("b2b_gap1", 32'(start_cyc[1] - start_cyc[0]), 32'(FRAME));
            check("b2b_gap2", 32'(start_cyc[2] - start_cyc[1]), 32'(FRAME));
        end

        // Overflow: six writes while busy
        ends0 = tx_end_cnt;
        check("ovf_clear_before", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) put(8'hA0 + 8'(i), i < 5);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        wait_idle("idle_ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ends_ovf", 32'(tx_end_cnt - ends0), 32'd5);

        // Reset mid-frame
        put(8'h33, 1'b0);
        put(8'h34, 1'b0);
        repeat (9) @(negedge clk);
        ends0 = tx_end_cnt;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        repeat (4) @(negedge clk);
        check("mid_rst_tx_hold", 32'(tx), 32'd1);
        reset = 1'b1;
        repeat (FRAME + 4) @(negedge clk);
        check("mid_rst_no_end", 32'(tx_end_cnt - ends0), 32'd0);
        check("mid_rst_no_frame", 32'(tx), 32'd1);

        // Fill and drain across pointer wrap
        ends0 = tx_end_cnt;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < DEPTH; i++) put(8'(b * DEPTH + i), 1'b1);
            wait_idle("idle_wrap");
        end
        check("ends_wrap", 32'(tx_end_cnt - ends0), 32'(3 * DEPTH));
        check("wrap_overflow", 32'(overflow), 32'd0);
        check("wrap_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
